// File: rtl/branch_target_buffer_pkg.sv
// Shared BTB definitions: default geometry, entry layout and PC-to-index/tag helpers.
package branch_target_buffer_pkg;

  localparam int BTB_INDEX_BITS = 6;
  localparam int BTB_TAG_BITS   = 24;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [31:0]             target;
    logic                    is_jump;
  } btb_entry_t;

  function automatic logic [31:0] btb_index(input logic [31:0] pc, input int index_bits);
    return (pc >> 2) & ((32'd1 << index_bits) - 32'd1);
  endfunction

  // Caller truncates to its tag width; bits above the tag field fall away there.
  function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int index_bits);
    return pc >> (index_bits + 2);
  endfunction

endpackage

// File: rtl/branch_target_buffer_storage.sv
// Direct-mapped BTB entry array: one async read port, one sync write port.
// Valid bits clear asynchronously on reset; tag/target/is_jump are left untouched.
module branch_target_buffer_storage #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] i_ridx,
  output logic                  o_valid,
  output logic [TAG_BITS-1:0]   o_tag,
  output logic [31:0]           o_target,
  output logic                  o_is_jump,
  input  logic                  i_we,
  input  logic [INDEX_BITS-1:0] i_widx,
  input  logic [TAG_BITS-1:0]   i_wtag,
  input  logic [31:0]           i_wtarget,
  input  logic                  i_wis_jump
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [DEPTH-1:0]    r_valid;
  logic [TAG_BITS-1:0] r_tag     [DEPTH];
  logic [31:0]         r_target  [DEPTH];
  logic                r_is_jump [DEPTH];

  // An update landing on the reset-release edge is dropped by the reset branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_widx]     <= i_wtag;
      r_target[i_widx]  <= i_wtarget;
      r_is_jump[i_widx] <= i_wis_jump;
    end
  end

  assign o_valid   = r_valid[i_ridx];
  assign o_tag     = r_tag[i_ridx];
  assign o_target  = r_target[i_ridx];
  assign o_is_jump = r_is_jump[i_ridx];

endmodule

// File: rtl/branch_target_buffer.sv
// Fetch-stage BTB: same-cycle next-PC prediction, registered decode copy one cycle later.
// Memory-stage updates are visible the cycle after the write edge; no read-during-write bypass.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int INDEX_BITS = BTB_INDEX_BITS,
  parameter int TAG_BITS   = BTB_TAG_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        flushD,
  input  logic [31:0] pcF,
  input  logic        pred_takeF,
  output logic [31:0] pred_pcF,
  output logic        btb_hitF,
  output logic        pred_redirectD,
  output logic [31:0] pred_targetD,
  input  logic        branchM,
  input  logic        jumpM,
  input  logic [31:0] pcM,
  input  logic        actual_takeM,
  input  logic [31:0] actual_targetM
);

  logic [INDEX_BITS-1:0] w_idxF, w_idxM;
  logic [TAG_BITS-1:0]   w_tagF, w_tagM, w_rd_tag;
  logic                  w_rd_valid, w_rd_is_jump;
  logic [31:0]           w_rd_target;
  logic                  w_hit, w_redirect, w_we;
  logic                  r_redirectD;
  logic [31:0]           r_targetD;

  assign w_idxF = INDEX_BITS'(btb_index(pcF, INDEX_BITS));
  assign w_tagF = TAG_BITS'(btb_tag(pcF, INDEX_BITS));
  assign w_idxM = INDEX_BITS'(btb_index(pcM, INDEX_BITS));
  assign w_tagM = TAG_BITS'(btb_tag(pcM, INDEX_BITS));

  // Not-taken branches never touch the table; direction learning lives elsewhere.
  assign w_we = jumpM | (branchM & actual_takeM);

  branch_target_buffer_storage #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_storage (
    .clk       (clk),
    .rst       (rst),
    .i_ridx    (w_idxF),
    .o_valid   (w_rd_valid),
    .o_tag     (w_rd_tag),
    .o_target  (w_rd_target),
    .o_is_jump (w_rd_is_jump),
    .i_we      (w_we),
    .i_widx    (w_idxM),
    .i_wtag    (w_tagM),
    .i_wtarget (actual_targetM),
    .i_wis_jump(jumpM)
  );

  assign w_hit      = w_rd_valid & (w_rd_tag == w_tagF);
  assign w_redirect = w_hit & (w_rd_is_jump | pred_takeF);
  assign pred_pcF   = w_redirect ? w_rd_target : pcF + 32'd4;
  assign btb_hitF   = w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirectD <= 1'b0;
      r_targetD   <= '0;
    end else if (flushD) begin
      r_redirectD <= 1'b0;
      r_targetD   <= '0;
    end else if (!stallD) begin
      r_redirectD <= w_redirect;
      r_targetD   <= w_redirect ? w_rd_target : 32'd0;
    end
  end

  assign pred_redirectD = r_redirectD;
  assign pred_targetD   = r_targetD;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer with hand-computed expectations.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallD, flushD;
  logic [31:0] pcF;
  logic        pred_takeF;
  logic [31:0] pred_pcF;
  logic        btb_hitF;
  logic        pred_redirectD;
  logic [31:0] pred_targetD;
  logic        branchM, jumpM, actual_takeM;
  logic [31:0] pcM, actual_targetM;

  int n_cmp = 0;
  int n_err = 0;

  branch_target_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .stallD        (stallD),
    .flushD        (flushD),
    .pcF           (pcF),
    .pred_takeF    (pred_takeF),
    .pred_pcF      (pred_pcF),
    .btb_hitF      (btb_hitF),
    .pred_redirectD(pred_redirectD),
    .pred_targetD  (pred_targetD),
    .branchM       (branchM),
    .jumpM         (jumpM),
    .pcM           (pcM),
    .actual_takeM  (actual_takeM),
    .actual_targetM(actual_targetM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic br, input logic jp, input logic tk,
                     input logic [31:0] pc, input logic [31:0] tgt);
    branchM = br; jumpM = jp; actual_takeM = tk; pcM = pc; actual_targetM = tgt;
  endtask

  task automatic no_upd();
    upd(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic look(input logic [31:0] pc, input logic tk);
    pcF = pc; pred_takeF = tk;
    #2;
  endtask

  initial begin
    rst = 1'b1; stallD = 1'b0; flushD = 1'b0;
    pcF = 32'h0; pred_takeF = 1'b0;
    no_upd();
    #1;
    chk("reset_redirectD", {31'b0, pred_redirectD}, 32'd0);
    chk("reset_targetD", pred_targetD, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Cold lookup
    look(32'h0040_0020, 1'b1);
    chk("cold_hit", {31'b0, btb_hitF}, 32'd0);
    chk("cold_pc", pred_pcF, 32'h0040_0024);
    tick();
    chk("cold_redirectD", {31'b0, pred_redirectD}, 32'd0);

    // Learn a taken branch; same-cycle lookup still sees the old (empty) entry
    upd(1'b1, 1'b0, 1'b1, 32'h0040_0020, 32'h0040_0100);
    look(32'h0040_0020, 1'b1);
    chk("learn_prewrite_hit", {31'b0, btb_hitF}, 32'd0);
    tick();
    no_upd();
    look(32'h0040_0020, 1'b0);
    chk("learn_nt_hit", {31'b0, btb_hitF}, 32'd1);
    chk("learn_nt_pc", pred_pcF, 32'h0040_0024);
    look(32'h0040_0020, 1'b1);
    chk("learn_t_pc", pred_pcF, 32'h0040_0100);
    tick();
    chk("learn_redirectD", {31'b0, pred_redirectD}, 32'd1);
    chk("learn_targetD", pred_targetD, 32'h0040_0100);

    // Jump ignores direction prediction
    upd(1'b0, 1'b1, 1'b0, 32'h0040_0040, 32'h0040_0800);
    look(32'h0040_0040, 1'b0);
    chk("jump_prewrite_pc", pred_pcF, 32'h0040_0044);
    tick();
    no_upd();
    look(32'h0040_0040, 1'b0);
    chk("jump_hit", {31'b0, btb_hitF}, 32'd1);
    chk("jump_pc", pred_pcF, 32'h0040_0800);
    tick();
    chk("jump_redirectD", {31'b0, pred_redirectD}, 32'd1);
    chk("jump_targetD", pred_targetD, 32'h0040_0800);
    look(32'h0040_0100, 1'b1);
    tick();
    chk("miss_redirectD", {31'b0, pred_redirectD}, 32'd0);
    chk("miss_targetD", pred_targetD, 32'd0);

    // Alias eviction at index 8
    upd(1'b1, 1'b0, 1'b1, 32'h0040_0020, 32'h0000_0100);
    tick();
    upd(1'b1, 1'b0, 1'b1, 32'h0040_1020, 32'h0000_0200);
    tick();
    no_upd();
    look(32'h0040_0020, 1'b1);
    chk("alias_old_hit", {31'b0, btb_hitF}, 32'd0);
    chk("alias_old_pc", pred_pcF, 32'h0040_0024);
    look(32'h0040_1020, 1'b1);
    chk("alias_new_pc", pred_pcF, 32'h0000_0200);

    // Same-cycle collision on index 8, then a not-taken branch that must not write
    upd(1'b1, 1'b0, 1'b1, 32'h0040_1020, 32'h0000_0300);
    look(32'h0040_1020, 1'b1);
    chk("collide_old_pc", pred_pcF, 32'h0000_0200);
    tick();
    no_upd();
    look(32'h0040_1020, 1'b1);
    chk("collide_new_pc", pred_pcF, 32'h0000_0300);
    upd(1'b1, 1'b0, 1'b0, 32'h0040_1020, 32'h0000_0400);
    tick();
    no_upd();
    look(32'h0040_1020, 1'b1);
    chk("nottaken_keep_pc", pred_pcF, 32'h0000_0300);

    // Taken branch over a jump entry clears is_jump
    upd(1'b1, 1'b0, 1'b1, 32'h0040_0040, 32'h0000_0500);
    tick();
    no_upd();
    look(32'h0040_0040, 1'b0);
    chk("isjump_clear_hit", {31'b0, btb_hitF}, 32'd1);
    chk("isjump_clear_pc", pred_pcF, 32'h0040_0044);

    // Stall holds, flush overrides stall
    look(32'h0040_1020, 1'b1);
    tick();
    chk("cap_targetD", pred_targetD, 32'h0000_0300);
    stallD = 1'b1;
    look(32'h0040_0020, 1'b1);
    tick();
    chk("stall1_targetD", pred_targetD, 32'h0000_0300);
    tick();
    chk("stall2_redirectD", {31'b0, pred_redirectD}, 32'd1);
    chk("stall2_targetD", pred_targetD, 32'h0000_0300);
    look(32'h0040_1020, 1'b1);
    flushD = 1'b1;
    tick();
    chk("flush_redirectD", {31'b0, pred_redirectD}, 32'd0);
    chk("flush_targetD", pred_targetD, 32'd0);
    flushD = 1'b0; stallD = 1'b0;

    // 32-bit wrap of sequential PC
    look(32'hFFFF_FFFC, 1'b0);
    chk("wrap_pc", pred_pcF, 32'h0000_0000);

    // Asynchronous reset mid-cycle; update on the release edge is dropped
    look(32'h0040_1020, 1'b1);
    tick();
    chk("prerst_redirectD", {31'b0, pred_redirectD}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_hit", {31'b0, btb_hitF}, 32'd0);
    chk("rst_pc", pred_pcF, 32'h0040_1024);
    chk("rst_redirectD", {31'b0, pred_redirectD}, 32'd0);
    chk("rst_targetD", pred_targetD, 32'd0);
    upd(1'b1, 1'b0, 1'b1, 32'h0040_0080, 32'h0000_0900);
    tick();
    rst = 1'b0;
    no_upd();
    look(32'h0040_0080, 1'b1);
    chk("rst_edge_drop_hit", {31'b0, btb_hitF}, 32'd0);
    chk("rst_edge_drop_pc", pred_pcF, 32'h0040_0084);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
